// File: rtl/cam_pixel_packetizer.sv
// Camera RGB565 to Avalon-ST 30-bit video packetizer with show-ahead FIFO and frame padding.
// Optional colour-bar generator enabled by defining CAM_PKT_TEST_PATTERN_EN.
module cam_pixel_packetizer #(
    parameter int unsigned FRAME_W    = 320,
    parameter int unsigned FRAME_H    = 240,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        frame_start,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    output logic [29:0] st_data,
    output logic        st_valid,
    input  logic        st_ready,
    output logic        st_sop,
    output logic        st_eop,
    output logic        overflow,
    input  logic        test_pattern
);

    localparam int unsigned TOTAL = FRAME_W * FRAME_H;
    localparam int unsigned CNT_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(TOTAL - 1);

    typedef enum logic [1:0] {StIdle, StActive, StFlush} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             overflow_q, overflow_d;

    logic [31:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             empty, full, pop, room;
    logic             wr_en;
    logic [29:0]      wr_data;
    logic [31:0]      wr_entry, head;
    logic             first_pix, last_pix;
    logic [29:0]      pix_wide, pix_word;

    assign empty = (count_q == '0);
    assign full  = (count_q == (PTR_W + 1)'(FIFO_DEPTH));
    assign pop   = !empty && st_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign room  = !full || pop;

    assign first_pix = (cnt_q == '0);
    assign last_pix  = (cnt_q == LAST_PIX);

    assign pix_wide = {pix_data[15:11], pix_data[15:11],
                       pix_data[10:5],  pix_data[10:7],
                       pix_data[4:0],   pix_data[4:0]};

`ifdef CAM_PKT_TEST_PATTERN_EN
    logic [2:0]  bar_idx;
    logic [29:0] bar_data;

    always_comb begin
        bar_idx = 3'(((32'(cnt_q) % FRAME_W) * 8) / FRAME_W);
        // Bar order white..black: R off for bars 2,3,6,7; G off for 4..7; B off for odd bars.
        bar_data = {{10{~bar_idx[1]}}, {10{~bar_idx[2]}}, {10{~bar_idx[0]}}};
        pix_word = test_pattern ? bar_data : pix_wide;
    end
`else
    logic unused_test_pattern;
    assign unused_test_pattern = test_pattern;
    assign pix_word = pix_wide;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        overflow_d = overflow_q;
        wr_en      = 1'b0;
        wr_data    = '0;
        unique case (state_q)
            StIdle: begin
                if (frame_start) begin
                    state_d = StActive;
                    cnt_d   = '0;
                end
            end
            StActive: begin
                if (frame_start) begin
                    if (!first_pix) state_d = StFlush;
                end else if (pix_valid) begin
                    if (room) begin
                        wr_en   = 1'b1;
                        wr_data = pix_word;
                    end else begin
                        overflow_d = 1'b1;
                        state_d    = StFlush;
                    end
                end
            end
            StFlush: begin
                wr_en = room;
            end
            default: state_d = StIdle;
        endcase
        if (wr_en) begin
            cnt_d = last_pix ? '0 : cnt_q + 1'b1;
            if (last_pix) state_d = StIdle;
        end
    end

    assign wr_entry = {first_pix, last_pix, wr_data};

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (PTR_W + 1)'(wr_en) - (PTR_W + 1)'(pop);
        end
    end

    always_ff @(posedge clk_clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_entry;
    end

    assign head     = mem_q[rd_ptr_q];
    assign st_valid = !empty;
    assign st_sop   = !empty && head[31];
    assign st_eop   = !empty && head[30];
    assign st_data  = empty ? '0 : head[29:0];
    assign overflow = overflow_q;

endmodule
